// File: rtl/fetch_queue.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_queue                                                              |
// | Instruction byte prefetch queue: one-outstanding-read memory fetcher,    |
// | circular byte buffer and 4-byte operand window for the decoder.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fetch_queue #(
  parameter int          DEPTH     = 8,
  parameter logic [31:0] RESET_EIP = 32'h0000_0000
) (
  input  logic        clk2,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_data,
  output logic [31:0] ope,
  output logic        ope_valid,
  output logic [31:0] eip,
  input  logic        consume,
  input  logic [3:0]  num_of_ope,
  input  logic        redirect,
  input  logic [31:0] redirect_addr
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_WAIT = 2'd1;
  localparam logic [1:0] c_DROP = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_state_next;
  logic               r_run;
  logic [31:0]        r_fetch_addr;
  logic [31:0]        r_drop_addr;
  logic [31:0]        r_eip;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic [7:0]         r_mem [DEPTH];

  logic               w_write;
  logic               w_consume_ok;
  logic               w_start;
  logic [c_CNT_W-1:0] w_num;
  logic [c_CNT_W-1:0] w_count_next;

  assign w_num        = c_CNT_W'(num_of_ope);
  assign w_write      = (r_state == c_WAIT) && mem_ack && !redirect;
  assign w_consume_ok = consume && !redirect && (num_of_ope != 4'd0) && (r_count >= w_num);
  // r_run delays the first request by one cycle after reset release.
  assign w_start      = r_run && !redirect && (r_count < c_FULL);
  assign w_count_next = r_count + c_CNT_W'(w_write) - (w_consume_ok ? w_num : '0);

  always_ff @(posedge clk2 or negedge reset) begin
    if (!reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // An ack always completes the outstanding read, even one being discarded.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_IDLE:  if (w_start) w_state_next = c_WAIT;
      c_WAIT: begin
        if (mem_ack)       w_state_next = c_IDLE;
        else if (redirect) w_state_next = c_DROP;
      end
      c_DROP:  if (mem_ack) w_state_next = c_IDLE;
      default: w_state_next = c_IDLE;
    endcase
  end

  always_comb begin
    mem_req  = (r_state == c_WAIT) || (r_state == c_DROP);
    mem_addr = (r_state == c_DROP) ? r_drop_addr : r_fetch_addr;
  end

  always_ff @(posedge clk2 or negedge reset) begin
    if (!reset) begin
      r_run        <= 1'b0;
      r_fetch_addr <= RESET_EIP;
      r_drop_addr  <= RESET_EIP;
      r_eip        <= RESET_EIP;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
    end else begin
      r_run <= 1'b1;
      if ((r_state == c_WAIT) && (w_state_next == c_DROP)) begin
        r_drop_addr <= r_fetch_addr;
      end
      if (redirect) begin
        r_fetch_addr <= redirect_addr;
        r_eip        <= redirect_addr;
        r_rd_ptr     <= '0;
        r_wr_ptr     <= '0;
        r_count      <= '0;
      end else begin
        if (w_write) begin
          r_wr_ptr     <= r_wr_ptr + 1'b1;
          r_fetch_addr <= r_fetch_addr + 32'd1;
        end
        if (w_consume_ok) begin
          r_rd_ptr <= r_rd_ptr + c_PTR_W'(num_of_ope);
          r_eip    <= r_eip + {28'd0, num_of_ope};
        end
        r_count <= w_count_next;
      end
    end
  end

  always_ff @(posedge clk2) begin
    if (w_write) begin
      r_mem[r_wr_ptr] <= mem_data;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_ope
    logic [c_PTR_W-1:0] w_idx;
    assign w_idx = r_rd_ptr + c_PTR_W'(i);
    assign ope[31-8*i -: 8] = (r_count > c_CNT_W'(i)) ? r_mem[w_idx] : 8'h00;
  end

  assign ope_valid = (r_count >= c_CNT_W'(4));
  assign eip       = r_eip;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fetch_queue                                                           |
// | Directed vector table plus hand sequences for fetch_queue.               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_fetch_queue;

  logic        clk2 = 1'b0;
  logic        reset;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_data;
  logic [31:0] ope;
  logic        ope_valid;
  logic [31:0] eip;
  logic        consume;
  logic [3:0]  num_of_ope;
  logic        redirect;
  logic [31:0] redirect_addr;

  logic        mem_auto;
  logic        tb_ack;
  logic [7:0]  tb_data;
  logic        m_ack;
  logic [7:0]  m_data;
  int          m_cnt;
  int          m_lat;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk2 = ~clk2;

  assign mem_ack  = mem_auto ? m_ack  : tb_ack;
  assign mem_data = mem_auto ? m_data : tb_data;

  fetch_queue #(.DEPTH(8), .RESET_EIP(32'h0000_0000)) dut (
    .clk2          (clk2),
    .reset         (reset),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_data      (mem_data),
    .ope           (ope),
    .ope_valid     (ope_valid),
    .eip           (eip),
    .consume       (consume),
    .num_of_ope    (num_of_ope),
    .redirect      (redirect),
    .redirect_addr (redirect_addr)
  );

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'd0:   return 8'h55;
      32'd1:   return 8'h89;
      32'd2:   return 8'he5;
      32'd3:   return 8'hb8;
      default: return a[7:0] + 8'h10;
    endcase
  endfunction

  // Instruction memory with m_lat idle cycles before each ack.
  initial begin
    m_ack  = 1'b0;
    m_data = 8'h00;
    m_cnt  = 0;
    forever begin
      @(negedge clk2);
      if (!mem_req) begin
        m_ack = 1'b0;
        m_cnt = 0;
      end else if (m_cnt >= m_lat) begin
        m_ack  = 1'b1;
        m_data = mem_byte(mem_addr);
        m_cnt  = 0;
      end else begin
        m_ack = 1'b0;
        m_cnt = m_cnt + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk_outputs(input string tag, input logic req, input logic [31:0] addr,
                             input logic [31:0] op, input logic vld, input logic [31:0] ip);
    chk({tag, "_req"},   32'(mem_req),   32'(req));
    chk({tag, "_addr"},  mem_addr,       addr);
    chk({tag, "_ope"},   ope,            op);
    chk({tag, "_valid"}, 32'(ope_valid), 32'(vld));
    chk({tag, "_eip"},   eip,            ip);
  endtask

  typedef struct {
    logic        redirect;
    logic [31:0] raddr;
    logic        consume;
    logic [3:0]  num;
    logic        ack;
    logic [7:0]  data;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic [31:0] exp_ope;
    logic        exp_valid;
    logic [31:0] exp_eip;
  } vec_t;

  vec_t vecs[26];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    reset = 1'b0; consume = 1'b0; num_of_ope = 4'd0; redirect = 1'b0;
    redirect_addr = 32'h0; mem_auto = 1'b0; tb_ack = 1'b0; tb_data = 8'h00; m_lat = 0;

    //          redir raddr         cons  num    ack   data    req   addr          ope            vld   eip
    vecs[0]  = '{1'b0, 32'h0,        1'b0, 4'd0, 1'b1, 8'h55, 1'b0, 32'h1,  32'h5500_0000, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h0,        1'b0, 4'd0, 1'b0, 8'h00, 1'b1, 32'h1,  32'h5500_0000, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 32'h0,        1'b0, 4'd0, 1'b1, 8'h89, 1'b0, 32'h2,  32'h5589_0000, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 32'h0,        1'b0, 4'd0, 1'b0, 8'h00, 1'b1, 32'h2,  32'h5589_0000, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 32'h0,        1'b0, 4'd0, 1'b1, 8'he5, 1'b0, 32'h3,  32'h5589_e500, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 32'h0,        1'b1, 4'd4, 1'b0, 8'h00, 1'b1, 32'h3,  32'h5589_e500, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 32'h0,        1'b0, 4'd0, 1'b1, 8'hb8, 1'b0, 32'h4,  32'h5589_e5b8, 1'b1, 32'h0};
    vecs[7]  = '{1'b0, 32'h0,        1'b1, 4'd1, 1'b0, 8'h00, 1'b1, 32'h4,  32'h89e5_b800, 1'b0, 32'h1};
    vecs[8]  = '{1'b0, 32'h0,        1'b1, 4'd1, 1'b1, 8'hc1, 1'b0, 32'h5,  32'he5b8_c100, 1'b0, 32'h2};
    vecs[9]  = '{1'b0, 32'h0,        1'b1, 4'd0, 1'b0, 8'h00, 1'b1, 32'h5,  32'he5b8_c100, 1'b0, 32'h2};
    vecs[10] = '{1'b0, 32'h0,        1'b0, 4'd0, 1'b1, 8'hc2, 1'b0, 32'h6,  32'he5b8_c1c2, 1'b1, 32'h2};
    vecs[11] = '{1'b0, 32'h0,        1'b1, 4'd5, 1'b0, 8'h00, 1'b1, 32'h6,  32'he5b8_c1c2, 1'b1, 32'h2};
    vecs[12] = '{1'b0, 32'h0,        1'b0, 4'd0, 1'b1, 8'hc3, 1'b0, 32'h7,  32'he5b8_c1c2, 1'b1, 32'h2};
    vecs[13] = '{1'b0, 32'h0,        1'b1, 4'd5, 1'b0, 8'h00, 1'b1, 32'h7,  32'h0000_0000, 1'b0, 32'h7};
    vecs[14] = '{1'b1, 32'h40,       1'b0, 4'd0, 1'b0, 8'h00, 1'b1, 32'h7,  32'h0000_0000, 1'b0, 32'h40};
    vecs[15] = '{1'b0, 32'h0,        1'b0, 4'd0, 1'b0, 8'h00, 1'b1, 32'h7,  32'h0000_0000, 1'b0, 32'h40};
    vecs[16] = '{1'b0, 32'h0,        1'b0, 4'd0, 1'b1, 8'hee, 1'b0, 32'h40, 32'h0000_0000, 1'b0, 32'h40};
    vecs[17] = '{1'b0, 32'h0,        1'b0, 4'd0, 1'b0, 8'h00, 1'b1, 32'h40, 32'h0000_0000, 1'b0, 32'h40};
    vecs[18] = '{1'b1, 32'h80,       1'b0, 4'd0, 1'b1, 8'h77, 1'b0, 32'h80, 32'h0000_0000, 1'b0, 32'h80};
    vecs[19] = '{1'b1, 32'h90,       1'b0, 4'd0, 1'b0, 8'h00, 1'b0, 32'h90, 32'h0000_0000, 1'b0, 32'h90};
    vecs[20] = '{1'b0, 32'h0,        1'b0, 4'd0, 1'b0, 8'h00, 1'b1, 32'h90, 32'h0000_0000, 1'b0, 32'h90};
    vecs[21] = '{1'b0, 32'h0,        1'b0, 4'd0, 1'b1, 8'h11, 1'b0, 32'h91, 32'h1100_0000, 1'b0, 32'h90};
    vecs[22] = '{1'b0, 32'h0,        1'b0, 4'd0, 1'b0, 8'h00, 1'b1, 32'h91, 32'h1100_0000, 1'b0, 32'h90};
    vecs[23] = '{1'b1, 32'ha0,       1'b1, 4'd1, 1'b0, 8'h00, 1'b1, 32'h91, 32'h0000_0000, 1'b0, 32'ha0};
    vecs[24] = '{1'b1, 32'hb0,       1'b0, 4'd0, 1'b0, 8'h00, 1'b1, 32'h91, 32'h0000_0000, 1'b0, 32'hb0};
    vecs[25] = '{1'b0, 32'h0,        1'b0, 4'd0, 1'b1, 8'h22, 1'b0, 32'hb0, 32'h0000_0000, 1'b0, 32'hb0};

    // Reset values held while reset is low, across clock edges.
    repeat (2) @(posedge clk2);
    #1;
    chk_outputs("reset", 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

    // First request appears after the second edge following release.
    reset = 1'b1;
    @(posedge clk2); #1;
    chk("first_edge_req", 32'(mem_req), 32'd0);
    @(posedge clk2); #1;
    chk("second_edge_req", 32'(mem_req), 32'd1);
    chk("second_edge_addr", mem_addr, 32'h0);

    for (int i = 0; i < 26; i++) begin
      redirect      = vecs[i].redirect;
      redirect_addr = vecs[i].raddr;
      consume       = vecs[i].consume;
      num_of_ope    = vecs[i].num;
      tb_ack        = vecs[i].ack;
      tb_data       = vecs[i].data;
      @(posedge clk2); #1;
      chk_outputs($sformatf("v%0d", i), vecs[i].exp_req, vecs[i].exp_addr,
                  vecs[i].exp_ope, vecs[i].exp_valid, vecs[i].exp_eip);
    end
    redirect = 1'b0; consume = 1'b0; num_of_ope = 4'd0; tb_ack = 1'b0;

    // Fill to saturation with a 3-cycle memory and no consumer.
    reset = 1'b0;
    #1;
    mem_auto = 1'b1;
    m_lat    = 3;
    @(posedge clk2); #1;
    reset = 1'b1;
    seen  = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk2); #1;
      if (ope_valid && !mem_req && mem_addr == 32'd8) begin
        seen = 1'b1;
        break;
      end
    end
    chk("fill_reached", 32'(seen), 32'd1);
    repeat (10) @(posedge clk2);
    #1;
    chk_outputs("full", 1'b0, 32'd8, 32'h5589_e5b8, 1'b1, 32'h0);

    consume    = 1'b1;
    num_of_ope = 4'd4;
    @(posedge clk2); #1;
    consume    = 1'b0;
    num_of_ope = 4'd0;
    chk("after_consume4_ope", ope, 32'h1415_1617);
    chk("after_consume4_eip", eip, 32'h4);
    chk("after_consume4_valid", 32'(ope_valid), 32'd1);

    // Asynchronous reset in the middle of an outstanding read.
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk2); #1;
      if (mem_req) begin
        seen = 1'b1;
        break;
      end
    end
    chk("wait_req_seen", 32'(seen), 32'd1);
    @(negedge clk2);
    #2;
    reset = 1'b0;
    #1;
    chk_outputs("async_reset", 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 8, byte-queue depth; power of two, minimum 8.
REQ-002 Parameter RESET_EIP, default 32'h0000_0000, eip and fetch address after reset.
REQ-003 clk2  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low; 0 resets all state immediately, release is synchronous to clk2.
REQ-005 mem_req  out  1  byte read request to instruction memory.
REQ-006 mem_addr  out  32  byte address of the pending request.
REQ-007 mem_ack  in  1  memory has driven mem_data this cycle; completes the request.
REQ-008 mem_data  in  8  returned instruction byte, valid only when mem_ack=1.
REQ-009 ope  out  32  next four instruction bytes, oldest in [31:24], then [23:16], [15:8], [7:0].
REQ-010 ope_valid  out  1  at least 4 bytes are queued.
REQ-011 eip  out  32  address of the byte presented in ope[31:24].
REQ-012 consume  in  1  the decoder retires the instruction at the queue head.
REQ-013 num_of_ope  in  4  byte length of the retired instruction, legal range 1..5.
REQ-014 redirect  in  1  control transfer (ret, loop); discards queue contents.
REQ-015 redirect_addr  in  32  new eip when redirect=1.

Function
REQ-016 The byte queue SHALL be a circular buffer of DEPTH bytes: 3-bit read/write pointers that wrap modulo DEPTH, plus a 4-bit count in the range 0..DEPTH.
REQ-017 A 3-state request FSM SHALL control memory reads: IDLE, WAIT, DROP.
REQ-018 IDLE->WAIT when count plus in-flight bytes < DEPTH and redirect=0; on that edge mem_req rises and mem_addr = fetch_addr.
REQ-019 In WAIT, mem_req and mem_addr SHALL remain stable until mem_ack; a request is never withdrawn.
REQ-020 WAIT with mem_ack and no redirect: write mem_data at the write pointer, increment fetch_addr by 1, go to IDLE; mem_req drops in the following cycle.
REQ-021 At most one request SHALL be outstanding; throughput is one byte per two cycles at zero-wait memory.
REQ-022 ope bytes at positions count..3 SHALL read as 8'h00 when count<4, and ope_valid = (count>=4).
REQ-023 consume=1 with count>=num_of_ope SHALL advance the read pointer and eip by num_of_ope, both modulo their widths.
REQ-024 consume=1 with count<num_of_ope or num_of_ope=0 SHALL be ignored, with no state change.
REQ-025 A simultaneous byte write and consume SHALL give count_next = count + 1 - num_of_ope.
REQ-026 redirect=1 SHALL take priority over consume and mem_ack; count goes to 0, both pointers to 0, eip and fetch_addr to redirect_addr.
REQ-027 Redirect in IDLE, or in WAIT coincident with mem_ack, SHALL drop any returned byte and leave the FSM in IDLE.
REQ-028 Redirect in WAIT without mem_ack SHALL move the FSM to DROP; mem_req stays high with the old address, the ack'd byte is discarded, then DROP->IDLE.
REQ-029 Redirect in DROP SHALL update eip and fetch_addr, and the FSM remains in DROP.
REQ-030 Queue full (count=DEPTH) SHALL block new requests; an in-flight byte always has a reserved slot.

Reset
REQ-031 While reset=0 the following SHALL hold: mem_req=0, mem_addr=RESET_EIP, eip=RESET_EIP, fetch_addr=RESET_EIP, count=0, pointers=0, FSM=IDLE, ope=0, ope_valid=0.
REQ-032 Reset asserted mid-request SHALL abandon the request; the memory model tolerates mem_req dropping.
REQ-033 The first request SHALL issue on the second rising clk2 edge after reset deassertion.

Verification
REQ-034 Zero-wait memory holding bytes 55 89 e5 b8 at 0..3 -> ope=32'h5589e5b8, ope_valid=1, eip=0 once count=4.
REQ-035 Consume with num_of_ope=1 on that state -> eip=1, ope[31:24]=8'h89, count=3 plus any ack in the same cycle.
REQ-036 No consume, 3-cycle ack latency -> count saturates at 8, mem_req stays 0, mem_addr=8.
REQ-037 Redirect to 32'h40 while in WAIT, ack 2 cycles later -> the acked byte is discarded, next mem_addr=32'h40, eip=32'h40, ope_valid=0.
REQ-038 Consume with num_of_ope=5 while count=4 -> no change; again at count=5 -> count=0 plus any ack in the same cycle, eip+=5.
REQ-039 reset driven low while in WAIT -> mem_req=0 and all outputs at reset values in the same cycle, no clock edge needed.
